// File: rtl/write_merge_buffer_pkg.sv
// Shared types and default geometry for the write merge buffer.
// The defaults match the LC3b data-cache line and word sizes.
package write_merge_buffer_pkg;

    typedef enum logic [1:0] {
        WMB_IDLE  = 2'd0,
        WMB_FILL  = 2'd1,
        WMB_DRAIN = 2'd2
    } wmb_state_t;

    localparam int lc3b_wmb_line_bytes = 16;
    localparam int lc3b_wmb_word_bytes = 2;
    localparam int lc3b_wmb_depth      = 4;
    localparam int lc3b_wmb_addr_w     = 16;
    localparam int lc3b_wmb_age_limit  = 32;

    // Index width that never collapses to zero bits for degenerate sizes.
    function automatic int clog2_min1(input int value);
        return (value > 1) ? $clog2(value) : 1;
    endfunction

endpackage

// File: rtl/write_merge_buffer_line_merge.sv
// Combinational byte-lane insert of one store word into a cache line.
// Unselected bytes and mask bits pass through unchanged.
module line_merge
    import write_merge_buffer_pkg::*;
#(
    parameter int LINE_BYTES = lc3b_wmb_line_bytes,
    parameter int WORD_BYTES = lc3b_wmb_word_bytes,
    parameter int WIDX_W     = clog2_min1(LINE_BYTES / WORD_BYTES)
) (
    input  logic [8*LINE_BYTES-1:0] line,
    input  logic [LINE_BYTES-1:0]   bmask,
    input  logic [WIDX_W-1:0]       word_idx,
    input  logic [8*WORD_BYTES-1:0] wdata,
    input  logic [WORD_BYTES-1:0]   wmask,
    output logic [8*LINE_BYTES-1:0] merged_line,
    output logic [LINE_BYTES-1:0]   merged_bmask
);

    genvar gi;
    generate
        for (gi = 0; gi < LINE_BYTES; gi++) begin : g_byte
            localparam int WORD = gi / WORD_BYTES;
            localparam int LANE = gi % WORD_BYTES;
            logic sel;

            assign sel = (word_idx == WIDX_W'(WORD)) && wmask[LANE];
            assign merged_line[8*gi +: 8] = sel ? wdata[8*LANE +: 8] : line[8*gi +: 8];
            assign merged_bmask[gi]       = bmask[gi] | sel;
        end
    endgenerate

endmodule

// File: rtl/write_merge_buffer.sv
// Coalescing store buffer: merges word stores into line entries and drains
// whole lines (data + byte mask) to the D-cache in allocation order.
module write_merge_buffer
    import write_merge_buffer_pkg::*;
#(
    parameter int LINE_BYTES = lc3b_wmb_line_bytes,
    parameter int WORD_BYTES = lc3b_wmb_word_bytes,
    parameter int DEPTH      = lc3b_wmb_depth,
    parameter int ADDR_W     = lc3b_wmb_addr_w,
    parameter int AGE_LIMIT  = lc3b_wmb_age_limit
) (
    input  logic                                  clk,
    input  logic                                  reset,
    input  logic                                  st_valid,
    output logic                                  st_ready,
    input  logic [ADDR_W-1:0]                     st_addr,
    input  logic [8*WORD_BYTES-1:0]               st_wdata,
    input  logic [WORD_BYTES-1:0]                 st_wmask,
    input  logic                                  flush,
    output logic                                  flush_done,
    output logic                                  drain_valid,
    input  logic                                  drain_ready,
    output logic [ADDR_W-$clog2(LINE_BYTES)-1:0]  drain_tag,
    output logic [8*LINE_BYTES-1:0]               drain_data,
    output logic [LINE_BYTES-1:0]                 drain_bmask,
    output logic                                  empty
);

    localparam int OFF_W      = $clog2(LINE_BYTES);
    localparam int WSH        = $clog2(WORD_BYTES);
    localparam int TAG_W      = ADDR_W - OFF_W;
    localparam int WIDX_W     = clog2_min1(LINE_BYTES / WORD_BYTES);
    localparam int PTR_W      = clog2_min1(DEPTH);
    localparam int CNT_W      = $clog2(DEPTH + 1);
    localparam int AGE_W      = clog2_min1(AGE_LIMIT + 1);
    localparam int AGE_THRESH = (AGE_LIMIT > 0) ? AGE_LIMIT - 1 : 0;
    localparam int LINE_W     = 8 * LINE_BYTES;

    wmb_state_t state_reg, state_next;

    logic [DEPTH-1:0]      valid_reg;
    logic [TAG_W-1:0]      tag_reg   [DEPTH];
    logic [LINE_W-1:0]     data_reg  [DEPTH];
    logic [LINE_BYTES-1:0] bmask_reg [DEPTH];

    logic [PTR_W-1:0] head_reg, tail_reg;
    logic [CNT_W-1:0] count_reg, count_next;
    logic [AGE_W-1:0] age_reg;
    logic             flush_pending_reg, flush_done_reg;

    logic [TAG_W-1:0]      st_tag;
    logic [WIDX_W-1:0]     word_idx;
    logic                  locked;
    logic [DEPTH-1:0]      hit_vec;
    logic                  hit;
    logic [PTR_W-1:0]      hit_idx;
    logic                  accept, do_write, do_merge, do_alloc, pop;
    logic                  age_expire, flush_complete;
    logic [LINE_W-1:0]     merge_line, alloc_line;
    logic [LINE_BYTES-1:0] merge_bmask, alloc_bmask;

    assign st_tag = st_addr[ADDR_W-1:OFF_W];

    generate
        if (LINE_BYTES > WORD_BYTES) begin : g_widx
            assign word_idx = st_addr[OFF_W-1:WSH];
        end else begin : g_widx_single
            assign word_idx = '0;
        end
        if (WSH > 0) begin : g_lsb
            // Sub-word address bits carry no information for word stores.
            logic unused_lsb;
            assign unused_lsb = ^st_addr[WSH-1:0];
        end
    endgenerate

    // The head is frozen while it is being offered to the cache.
    assign locked = (state_reg == WMB_DRAIN);

    genvar gi;
    generate
        for (gi = 0; gi < DEPTH; gi++) begin : g_hit
            assign hit_vec[gi] = valid_reg[gi] && (tag_reg[gi] == st_tag)
                                 && !(locked && (head_reg == PTR_W'(gi)));
        end
    endgenerate

    assign hit = |hit_vec;

    always_comb begin
        hit_idx = '0;
        for (int i = 0; i < DEPTH; i++) begin
            if (hit_vec[i]) begin
                hit_idx = PTR_W'(i);
            end
        end
    end

    assign st_ready   = !flush_pending_reg && (hit || (count_reg < CNT_W'(DEPTH)));
    assign accept     = st_valid && st_ready;
    assign do_write   = accept && (|st_wmask);
    assign do_merge   = do_write && hit;
    assign do_alloc   = do_write && !hit;
    assign pop        = locked && drain_ready;
    assign count_next = count_reg + CNT_W'(do_alloc) - CNT_W'(pop);
    assign age_expire = (AGE_LIMIT != 0) && (age_reg >= AGE_W'(AGE_THRESH));

    // A store arriving together with the flush request still lands first.
    assign flush_complete = (flush_pending_reg || flush) && (count_reg == '0) && !do_alloc;

    line_merge #(
        .LINE_BYTES (LINE_BYTES),
        .WORD_BYTES (WORD_BYTES),
        .WIDX_W     (WIDX_W)
    ) u_merge (
        .line         (data_reg[hit_idx]),
        .bmask        (bmask_reg[hit_idx]),
        .word_idx     (word_idx),
        .wdata        (st_wdata),
        .wmask        (st_wmask),
        .merged_line  (merge_line),
        .merged_bmask (merge_bmask)
    );

    line_merge #(
        .LINE_BYTES (LINE_BYTES),
        .WORD_BYTES (WORD_BYTES),
        .WIDX_W     (WIDX_W)
    ) u_alloc (
        .line         ('0),
        .bmask        ('0),
        .word_idx     (word_idx),
        .wdata        (st_wdata),
        .wmask        (st_wmask),
        .merged_line  (alloc_line),
        .merged_bmask (alloc_bmask)
    );

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            valid_reg <= '0;
            for (int i = 0; i < DEPTH; i++) begin
                tag_reg[i]   <= '0;
                data_reg[i]  <= '0;
                bmask_reg[i] <= '0;
            end
        end else begin
            if (pop) begin
                valid_reg[head_reg] <= 1'b0;
            end
            if (do_alloc) begin
                valid_reg[tail_reg] <= 1'b1;
                tag_reg[tail_reg]   <= st_tag;
                data_reg[tail_reg]  <= alloc_line;
                bmask_reg[tail_reg] <= alloc_bmask;
            end
            if (do_merge) begin
                data_reg[hit_idx]  <= merge_line;
                bmask_reg[hit_idx] <= merge_bmask;
            end
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            head_reg          <= '0;
            tail_reg          <= '0;
            count_reg         <= '0;
            age_reg           <= '0;
            flush_pending_reg <= 1'b0;
            flush_done_reg    <= 1'b0;
        end else begin
            if (pop) begin
                head_reg <= head_reg + PTR_W'(1);
            end
            if (do_alloc) begin
                tail_reg <= tail_reg + PTR_W'(1);
            end
            count_reg <= count_next;

            if ((state_reg == WMB_IDLE) || pop) begin
                age_reg <= '0;
            end else if (age_reg != AGE_W'(AGE_LIMIT)) begin
                age_reg <= age_reg + AGE_W'(1);
            end

            if (flush_complete) begin
                flush_pending_reg <= 1'b0;
                flush_done_reg    <= 1'b1;
            end else begin
                flush_done_reg <= 1'b0;
                if (flush) begin
                    flush_pending_reg <= 1'b1;
                end
            end
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_reg <= WMB_IDLE;
        end else begin
            state_reg <= state_next;
        end
    end

    // age_expire fires on the AGE_LIMIT-th cycle the head has waited.
    always_comb begin
        state_next = state_reg;
        case (state_reg)
            WMB_IDLE: begin
                if (do_alloc) begin
                    state_next = WMB_FILL;
                end
            end
            WMB_FILL: begin
                if ((count_reg == CNT_W'(DEPTH)) || flush_pending_reg || age_expire) begin
                    state_next = WMB_DRAIN;
                end
            end
            WMB_DRAIN: begin
                if (pop) begin
                    if (count_next == '0) begin
                        state_next = WMB_IDLE;
                    end else if (flush_pending_reg || (count_next == CNT_W'(DEPTH))) begin
                        state_next = WMB_DRAIN;
                    end else begin
                        state_next = WMB_FILL;
                    end
                end
            end
            default: state_next = WMB_IDLE;
        endcase
    end

    always_comb begin
        drain_valid = locked;
        drain_tag   = '0;
        drain_data  = '0;
        drain_bmask = '0;
        if (locked) begin
            drain_tag   = tag_reg[head_reg];
            drain_data  = data_reg[head_reg];
            drain_bmask = bmask_reg[head_reg];
        end
        empty      = (count_reg == '0);
        flush_done = flush_done_reg;
    end

endmodule

// File: tb/tb_write_merge_buffer.sv
// Directed bench for write_merge_buffer with a queue-based reference model
// checked on every falling edge.
module tb_write_merge_buffer;

    logic         clk = 1'b0;
    logic         reset;
    logic         st_valid;
    logic         st_ready;
    logic [15:0]  st_addr;
    logic [15:0]  st_wdata;
    logic [1:0]   st_wmask;
    logic         flush;
    logic         flush_done;
    logic         drain_valid;
    logic         drain_ready;
    logic [11:0]  drain_tag;
    logic [127:0] drain_data;
    logic [15:0]  drain_bmask;
    logic         empty;

    always #5 clk = ~clk;

    write_merge_buffer dut (
        .clk         (clk),
        .reset       (reset),
        .st_valid    (st_valid),
        .st_ready    (st_ready),
        .st_addr     (st_addr),
        .st_wdata    (st_wdata),
        .st_wmask    (st_wmask),
        .flush       (flush),
        .flush_done  (flush_done),
        .drain_valid (drain_valid),
        .drain_ready (drain_ready),
        .drain_tag   (drain_tag),
        .drain_data  (drain_data),
        .drain_bmask (drain_bmask),
        .empty       (empty)
    );

    typedef struct {
        logic [11:0]  tag;
        logic [127:0] data;
        logic [15:0]  bmask;
    } ent_t;

    ent_t mq[$];     // model contents, oldest first
    ent_t pops[$];   // lines observed leaving the DUT
    bit   m_pend;
    bit   m_done;
    int   n_cmp = 0;
    int   n_fail = 0;

    task automatic chk(input string name, input logic [127:0] act, input logic [127:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h want %0h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic expire(input string name);
        n_cmp++;
        n_fail++;
        $display("FAIL %s: got timeout want event at %0t", name, $time);
    endtask

    // Reference model: a FIFO of lines; a store merges into the youngest
    // matching line unless that line is the one being offered to the cache.
    always @(negedge clk) begin : model
        int          hit;
        int          widx;
        bit          exp_rdy, acc, alloc, pop, nd;
        logic [11:0] t;
        ent_t        e;
        ent_t        o;

        if (reset) begin
            mq.delete();
            m_pend = 1'b0;
            m_done = 1'b0;
        end
        t    = st_addr[15:4];
        widx = int'(st_addr[3:1]);
        hit  = -1;
        foreach (mq[i]) begin
            if (mq[i].tag == t && !(i == 0 && drain_valid)) hit = i;
        end
        exp_rdy = !m_pend && (hit >= 0 || mq.size() < 4);

        chk("empty", empty, mq.size() == 0);
        chk("st_ready", st_ready, exp_rdy);
        chk("flush_done", flush_done, m_done);
        if (drain_valid) begin
            if (mq.size() == 0) begin
                chk("drain_valid_while_empty", drain_valid, 1'b0);
            end else begin
                chk("drain_tag", drain_tag, mq[0].tag);
                chk("drain_data", drain_data, mq[0].data);
                chk("drain_bmask", drain_bmask, mq[0].bmask);
            end
        end

        if (!reset) begin
            pop   = drain_valid && drain_ready;
            acc   = st_valid && exp_rdy && (st_wmask != 2'b00);
            alloc = acc && (hit < 0);
            nd    = (m_pend || flush) && (mq.size() == 0) && !alloc;
            m_pend = nd ? 1'b0 : (m_pend || flush);
            m_done = nd;
            if (acc) begin
                if (hit >= 0) begin
                    e = mq[hit];
                end else begin
                    e.tag   = t;
                    e.data  = '0;
                    e.bmask = '0;
                end
                for (int l = 0; l < 2; l++) begin
                    if (st_wmask[l]) begin
                        e.data[8*(widx*2+l) +: 8] = st_wdata[8*l +: 8];
                        e.bmask[widx*2+l]         = 1'b1;
                    end
                end
                if (hit >= 0) mq[hit] = e;
                else mq.push_back(e);
            end
            if (pop) begin
                o.tag   = drain_tag;
                o.data  = drain_data;
                o.bmask = drain_bmask;
                pops.push_back(o);
                if (mq.size() > 0) void'(mq.pop_front());
            end
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Entered and left just after a rising edge.
    task automatic do_store(input logic [15:0] a, input logic [15:0] d, input logic [1:0] m);
        int w;
        st_valid = 1'b1;
        st_addr  = a;
        st_wdata = d;
        st_wmask = m;
        w = 0;
        forever begin
            @(negedge clk);
            if (st_ready) break;
            w++;
            if (w > 200) begin
                expire("store_wait");
                break;
            end
        end
        tick();
        st_valid = 1'b0;
    endtask

    task automatic pulse_flush();
        flush = 1'b1;
        tick();
        flush = 1'b0;
    endtask

    task automatic wait_dv(input int bound);
        int k;
        k = 0;
        forever begin
            @(negedge clk);
            if (drain_valid) break;
            k++;
            if (k > bound) begin
                expire("drain_valid_wait");
                break;
            end
        end
        tick();
    endtask

    task automatic drain_all(input int bound);
        int k;
        drain_ready = 1'b1;
        k = 0;
        forever begin
            @(negedge clk);
            if (empty) break;
            k++;
            if (k > bound) begin
                expire("drain_all_wait");
                break;
            end
        end
        tick();
        drain_ready = 1'b0;
    endtask

    initial begin : stim
        logic [11:0] t3_tags [5];
        int          k;

        t3_tags = '{12'h010, 12'h011, 12'h012, 12'h013, 12'h014};
        reset       = 1'b1;
        st_valid    = 1'b0;
        st_addr     = '0;
        st_wdata    = '0;
        st_wmask    = '0;
        flush       = 1'b0;
        drain_ready = 1'b0;

        #1;
        chk("rst_st_ready", st_ready, 1'b1);
        chk("rst_empty", empty, 1'b1);
        chk("rst_drain_valid", drain_valid, 1'b0);
        chk("rst_flush_done", flush_done, 1'b0);
        chk("rst_drain_tag", drain_tag, 12'h000);
        chk("rst_drain_data", drain_data, 128'h0);
        chk("rst_drain_bmask", drain_bmask, 16'h0000);
        repeat (2) @(posedge clk);
        #1;
        reset = 1'b0;

        // zero-mask store, then flush while empty
        do_store(16'h0000, 16'hFFFF, 2'b00);
        @(negedge clk);
        chk("t6_empty_after_nomask", empty, 1'b1);
        tick();
        pulse_flush();
        @(negedge clk);
        chk("t6_flush_done", flush_done, 1'b1);
        @(negedge clk);
        chk("t6_flush_done_pulse", flush_done, 1'b0);
        tick();

        // two stores merge into one line, flushed out
        do_store(16'h1002, 16'hBEEF, 2'b11);
        do_store(16'h1004, 16'h1234, 2'b01);
        @(negedge clk);
        chk("t2_one_entry", empty, 1'b0);
        tick();
        pulse_flush();
        wait_dv(20);
        @(negedge clk);
        chk("t2_tag", drain_tag, 12'h100);
        chk("t2_data", drain_data, 128'h0000_0000_0000_0000_0000_0034_BEEF_0000);
        chk("t2_bmask", drain_bmask, 16'h001C);
        tick();
        drain_ready = 1'b1;
        tick();
        drain_ready = 1'b0;
        @(negedge clk);
        chk("t2_flush_done_early", flush_done, 1'b0);
        @(negedge clk);
        chk("t2_flush_done", flush_done, 1'b1);
        tick();

        // fill all four entries, blocked store, merge while full
        pops.delete();
        do_store(16'h0100, 16'hA001, 2'b11);
        do_store(16'h0110, 16'hA002, 2'b11);
        do_store(16'h0120, 16'hA003, 2'b11);
        do_store(16'h0130, 16'hA004, 2'b11);
        st_valid = 1'b1;
        st_addr  = 16'h0140;
        st_wdata = 16'h4444;
        st_wmask = 2'b11;
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            chk("t3_full_blocks", st_ready, 1'b0);
            tick();
        end
        do_store(16'h0112, 16'h00AA, 2'b01);
        st_valid = 1'b1;
        st_addr  = 16'h0140;
        @(negedge clk);
        chk("t3_drain_valid", drain_valid, 1'b1);
        chk("t3_head_tag", drain_tag, 12'h010);
        chk("t3_still_blocked", st_ready, 1'b0);
        tick();
        drain_ready = 1'b1;
        @(negedge clk);
        chk("t3_no_pop_bypass", st_ready, 1'b0);
        tick();
        drain_ready = 1'b0;
        do_store(16'h0140, 16'h4444, 2'b11);
        drain_all(400);
        chk("t3_pop_count", pops.size(), 5);
        if (pops.size() == 5) begin
            for (int i = 0; i < 5; i++) chk("t3_pop_order", pops[i].tag, t3_tags[i]);
            chk("t3_merged_line", pops[1].data, 128'h0000_0000_0000_0000_0000_0000_00AA_A002);
        end

        // store to the locked head opens a new entry
        pops.delete();
        do_store(16'h0200, 16'h1111, 2'b11);
        wait_dv(60);
        for (int i = 0; i < 10; i++) begin
            @(negedge clk);
            chk("t4_held", drain_valid, 1'b1);
            tick();
        end
        do_store(16'h0202, 16'h2222, 2'b11);
        @(negedge clk);
        chk("t4_head_tag", drain_tag, 12'h020);
        chk("t4_head_data", drain_data, 128'h1111);
        chk("t4_head_bmask", drain_bmask, 16'h0003);
        chk("t4_two_entries", empty, 1'b0);
        tick();
        drain_all(200);
        chk("t4_pop_count", pops.size(), 2);
        if (pops.size() == 2) begin
            chk("t4_first_data", pops[0].data, 128'h1111);
            chk("t4_second_tag", pops[1].tag, 12'h020);
            chk("t4_second_data", pops[1].data, 128'h2222_0000);
            chk("t4_second_bmask", pops[1].bmask, 16'h000C);
        end

        // age-forced drain latency
        do_store(16'h0300, 16'h0055, 2'b01);
        k = 0;
        forever begin
            @(negedge clk);
            if (drain_valid) break;
            k++;
            if (k > 60) break;
        end
        chk("t5_age_latency", k, 32);
        tick();
        drain_all(10);

        // reset while a line is being offered
        do_store(16'h0400, 16'h7777, 2'b11);
        pulse_flush();
        wait_dv(20);
        @(negedge clk);
        #2;
        reset = 1'b1;
        #1;
        chk("t1_drain_valid_async", drain_valid, 1'b0);
        chk("t1_empty_async", empty, 1'b1);
        chk("t1_st_ready_async", st_ready, 1'b1);
        @(posedge clk);
        @(negedge clk);
        chk("t1_drain_valid_held", drain_valid, 1'b0);
        @(posedge clk);
        #1;
        reset = 1'b0;
        @(negedge clk);
        chk("t1_empty_after", empty, 1'b1);
        chk("t1_drain_valid_after", drain_valid, 1'b0);
        tick();

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule
